aurora_seq_framer: RTL and testbench

//  Parametrised TX-side framer between the VILLAS AXI-Stream source and the Aurora 8b10b TX port.

---
 rtl/aurora_pkg.sv | 22 ++
 rtl/aurora_sdp_ram.sv | 23 ++
 rtl/aurora_seq_framer.sv | 202 ++++++++++++++++++++
 tb/tb_aurora_seq_framer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared types and helpers for the Aurora TX sequence framer.
`timescale 1ns/1ps
package aurora_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StSeq
  } fsm_state_t;

  // Write-side mode: WrDrop discards the rest of an oversize packet up to its tlast.
  typedef enum logic {
    WrPass,
    WrDrop
  } wr_mode_t;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/aurora_sdp_ram.sv
// Simple dual-port buffer RAM with registered read; maps onto BRAM or LUTRAM.
`timescale 1ns/1ps
module aurora_sdp_ram #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/aurora_seq_framer.sv
// Store-and-forward AXI-Stream framer feeding Aurora TX; appends a sequence word per frame.
// Optional `AURORA_SEQ_STATS_EN adds saturating frame and drop counters.
`timescale 1ns/1ps
module aurora_seq_framer
  import aurora_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SEQ_WIDTH     = 32,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned MAX_PKT_WORDS = DEPTH
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_aresetn,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic                    ctrl_seq_en,
  input  logic                    ctrl_seq_clr,
  output logic [SEQ_WIDTH-1:0]    stat_seq,
  output logic                    stat_drop,
  output logic [31:0]             stat_pkt_cnt,
  output logic [31:0]             stat_drop_cnt
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = ptr_width(DEPTH);

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      word_cnt_q, word_cnt_d;
  wr_mode_t             wr_mode_q, wr_mode_d;
  logic                 rdy_en_q, stat_drop_q, stat_drop_d;
  fsm_state_t           state_q, state_d;
  logic                 seq_en_q, seq_en_d, tvalid_q, tvalid_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 ram_we, ram_re, full, s_hs;
  logic [DATA_WIDTH:0]  ram_rdata;
  logic [DATA_WIDTH-1:0] seq_word;

  assign full = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign s_axis_tready = rdy_en_q && ((wr_mode_q == WrDrop) || !full);
  assign s_hs = s_axis_tvalid && s_axis_tready;

  // tlast travels alongside each payload word so the reader knows where the packet ends.
  aurora_sdp_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (m_axis_aclk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AddrW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[AddrW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    word_cnt_d   = word_cnt_q;
    wr_mode_d    = wr_mode_q;
    stat_drop_d  = 1'b0;
    ram_we       = 1'b0;
    if (s_hs) begin
      if (wr_mode_q == WrDrop) begin
        if (s_axis_tlast) begin
          wr_mode_d   = WrPass;
          wr_ptr_d    = commit_ptr_q;
          stat_drop_d = 1'b1;
        end
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (s_axis_tlast) begin
          commit_ptr_d = wr_ptr_q + PtrW'(1);
          word_cnt_d   = '0;
        end else if (word_cnt_q == PtrW'(MAX_PKT_WORDS - 1)) begin
          wr_mode_d  = WrDrop;
          word_cnt_d = '0;
        end else begin
          word_cnt_d = word_cnt_q + PtrW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    seq_en_d = seq_en_q;
    tvalid_d = tvalid_q;
    seq_d    = seq_q;
    ram_re   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit_ptr_q != rd_ptr_q) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          seq_en_d = ctrl_seq_en;
          tvalid_d = 1'b1;
          state_d  = StData;
        end
      end
      StData: begin
        if (m_axis_tready) begin
          if (ram_rdata[DATA_WIDTH]) begin
            if (seq_en_q) begin
              state_d = StSeq;
            end else begin
              state_d  = StIdle;
              tvalid_d = 1'b0;
            end
          end else begin
            // Prefetch the next word so the frame streams without bubbles.
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + PtrW'(1);
          end
        end
      end
      StSeq: begin
        if (m_axis_tready) begin
          seq_d    = seq_q + SEQ_WIDTH'(1);
          state_d  = StIdle;
          tvalid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (ctrl_seq_clr) seq_d = '0;
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      word_cnt_q   <= '0;
      wr_mode_q    <= WrPass;
      rdy_en_q     <= 1'b0;
      stat_drop_q  <= 1'b0;
      state_q      <= StIdle;
      seq_en_q     <= 1'b0;
      tvalid_q     <= 1'b0;
      seq_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_cnt_q   <= word_cnt_d;
      wr_mode_q    <= wr_mode_d;
      rdy_en_q     <= 1'b1;
      stat_drop_q  <= stat_drop_d;
      state_q      <= state_d;
      seq_en_q     <= seq_en_d;
      tvalid_q     <= tvalid_d;
      seq_q        <= seq_d;
    end
  end

  always_comb begin
    seq_word = '0;
    seq_word[SEQ_WIDTH-1:0] = seq_q;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = (state_q == StSeq) ? seq_word : ram_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast  = (state_q == StSeq) ||
                         ((state_q == StData) && ram_rdata[DATA_WIDTH] && !seq_en_q);
  assign m_axis_tkeep  = '1;
  assign stat_seq      = seq_q;
  assign stat_drop     = stat_drop_q;

`ifdef AURORA_SEQ_STATS_EN
  logic [31:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (frame_cnt_q != '1)) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (stat_drop_q && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign stat_pkt_cnt  = frame_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_seq_framer.sv
// Scoreboard bench for aurora_seq_framer: a packet-level model queues expected frames,
// a negedge monitor pops and compares every accepted output word.
`timescale 1ns/1ps
module tb_aurora_seq_framer;

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXW  = 8;

  logic          clk, rst_n;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [DW/8-1:0] m_tkeep;
  logic          seq_en, seq_clr, stat_drop;
  logic [SW-1:0] stat_seq;
  logic [31:0]   stat_pkt_cnt, stat_drop_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  int unsigned model_seq = 0;
  int          exp_frames = 0;
  int          exp_drops = 0;
  int          drops_seen = 0;
  int          tready_mode = 1;  // 0: random, 1: always ready, 2: stalled

  aurora_seq_framer #(
    .DATA_WIDTH    (DW),
    .SEQ_WIDTH     (SW),
    .DEPTH         (DEPTH),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .ctrl_seq_en    (seq_en),
    .ctrl_seq_clr   (seq_clr),
    .stat_seq       (stat_seq),
    .stat_drop      (stat_drop),
    .stat_pkt_cnt   (stat_pkt_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tready_mode == 0) m_tready = ($urandom_range(0, 3) != 0);
      else m_tready = (tready_mode == 1);
    end
  end

  // Output monitor: scoreboard pop, hold-stability and drop-pulse tracking.
  logic        stalled = 1'b0;
  logic        drop_prev = 1'b0;
  logic [32:0] held, e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled   = 1'b0;
        drop_prev = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(m_tvalid), 64'd1);
          check("hold_word", 64'({m_tlast, m_tdata}), 64'(held));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got %0h expected no output", {m_tlast, m_tdata});
          end else begin
            e = exp_q.pop_front();
            check("out_word", 64'({m_tlast, m_tdata}), 64'(e));
            check("tkeep", 64'(m_tkeep), 64'hf);
          end
        end
        stalled = m_tvalid && !m_tready;
        held    = {m_tlast, m_tdata};
        if (stat_drop) begin
          drops_seen++;
          check("drop_pulse_width", 64'(drop_prev), 64'd0);
        end
        drop_prev = stat_drop;
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int guard = 0;
    if (tready_mode == 0 && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      @(negedge clk);
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!s_tready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      n_checks++;
      n_errors++;
      $display("FAIL s_tready_timeout: got tready=0 expected 1 within 5000 cycles");
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Model: a packet no longer than MAXW becomes its words plus an optional seq word.
  task automatic send_pkt(input int len, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] w[$];
    for (int i = 0; i < len; i++) w.push_back(rnd ? DW'($urandom) : base + DW'(i));
    if (len <= int'(MAXW)) begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) && !seq_en, w[i]});
      if (seq_en) begin
        exp_q.push_back({1'b1, 28'h0, 4'(model_seq)});
        model_seq = (model_seq + 1) % (1 << SW);
      end
      exp_frames++;
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < len; i++) send_word(w[i], i == len - 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", 64'(t < 4000), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_stat_drop", 64'(stat_drop), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_stat_seq", 64'(stat_seq), 64'd0);
    exp_q.delete();
    model_seq  = 0;
    exp_frames = 0;
    exp_drops  = 0;
    drops_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("ready_low_at_release", 64'(s_tready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(s_tready), 64'd1);
  endtask

  task automatic pulse_clr();
    seq_clr = 1'b1;
    @(negedge clk);
    seq_clr   = 1'b0;
    model_seq = 0;
    check("stat_seq_after_clr", 64'(stat_seq), 64'd0);
  endtask

  initial begin
    int t;
    rst_n = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    seq_en = 1'b1; seq_clr = 1'b0;
    #2;
    do_reset();

    // Directed frames with seq appended, then seq disabled.
    send_pkt(3, 32'hA, 1'b0);
    send_pkt(2, 32'h100, 1'b0);
    wait_drain();
    check("stat_seq_after_two", 64'(stat_seq), 64'd2);
    seq_en = 1'b0;
    send_pkt(2, 32'h200, 1'b0);
    wait_drain();
    check("stat_seq_no_seq", 64'(stat_seq), 64'd2);

    // Oversize drops around the MAXW boundary.
    seq_en = 1'b1;
    tready_mode = 0;
    send_pkt(10, 32'h0, 1'b1);
    send_pkt(2, 32'h0, 1'b1);
    send_pkt(int'(MAXW), 32'h0, 1'b1);
    send_pkt(int'(MAXW) + 1, 32'h0, 1'b1);
    wait_drain();
    check("drop_pulses", 64'(drops_seen), 64'(exp_drops));
    check("stat_seq_after_drop", 64'(stat_seq), 64'(model_seq));

    // Full buffer with output stalled, then release.
    tready_mode = 2;
    fork
      begin
        repeat (4) send_pkt(5, 32'h0, 1'b1);
      end
      begin
        repeat (80) @(negedge clk);
        check("full_tready_low", 64'(s_tready), 64'd0);
        check("full_tvalid_held", 64'(m_tvalid), 64'd1);
        tready_mode = 0;
      end
    join
    wait_drain();

    // Asynchronous reset in the middle of a stalled frame.
    tready_mode = 2;
    send_pkt(3, 32'h300, 1'b0);
    t = 0;
    while (!m_tvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("frame_started", 64'(m_tvalid), 64'd1);
    repeat (2) @(negedge clk);
    #3;
    do_reset();
    tready_mode = 0;
    send_pkt(2, 32'h400, 1'b0);
    wait_drain();
    repeat (20) @(negedge clk);

    // Sequence wrap over 17 frames, then clear.
    for (int i = 0; i < 17; i++) send_pkt(int'($urandom_range(1, 3)), 32'h0, 1'b1);
    wait_drain();
    check("stat_seq_wrap", 64'(stat_seq), 64'(model_seq));
    pulse_clr();
    send_pkt(1, 32'h500, 1'b0);
    wait_drain();

    // Random batches.
    for (int b = 0; b < 5; b++) begin
      seq_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) pulse_clr();
      for (int p = 0; p < 8; p++) send_pkt(int'($urandom_range(1, 11)), 32'h0, 1'b1);
      wait_drain();
      check("stat_seq_batch", 64'(stat_seq), 64'(model_seq));
      check("drops_batch", 64'(drops_seen), 64'(exp_drops));
    end

`ifdef AURORA_SEQ_STATS_EN
    check("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_frames));
    check("stat_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drops));
`else
    check("stat_pkt_cnt_tied", 64'(stat_pkt_cnt), 64'd0);
    check("stat_drop_cnt_tied", 64'(stat_drop_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
